// File: rtl/main_if.sv
// rtl/main_if.sv - keyboard controller I/O bundle
// Inputs come from the panel (keys, octave, song buttons, mode); outputs go to the speaker and display.
interface main_if;
   logic [2:0] mode_select;
   logic [6:0] key_in;
   logic [1:0] octave_keys;
   logic       next_song;
   logic       prev_song;
   logic       speaker;
   logic [6:0] song_num;
   logic [3:0] note_out;

   modport master (
      output mode_select, key_in, octave_keys, next_song, prev_song,
      input  speaker, song_num, note_out
   );

   modport slave (
      input  mode_select, key_in, octave_keys, next_song, prev_song,
      output speaker, song_num, note_out
   );
endinterface

// File: rtl/main.sv
// rtl/main.sv - electronic keyboard controller: free play, auto play, learn mode
// Inputs are registered once; note, song and tone state are registered again before leaving the block.
module main #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int NOTE_TICKS = 12_500_000,
   parameter int NUM_SONGS  = 4,
   parameter int SONG_LEN   = 16
) (
   input logic   clk,
   input logic   reset,
   main_if.slave bus
);

   localparam logic [6:0]  SONG_LAST = 7'(NUM_SONGS - 1);
   localparam logic [7:0]  IDX_LAST  = 8'(SONG_LEN - 1);
   localparam logic [31:0] TICK_LAST = 32'(NOTE_TICKS - 1);

   localparam logic [2:0] MODE_FREE  = 3'd0;
   localparam logic [2:0] MODE_AUTO  = 3'd1;
   localparam logic [2:0] MODE_LEARN = 3'd2;

   function automatic logic [31:0] half_of(input logic [3:0] deg, input logic [1:0] oct);
      logic [31:0] base;
      case (deg)
         4'd1:    base = 32'(CLK_HZ / 524);
         4'd2:    base = 32'(CLK_HZ / 588);
         4'd3:    base = 32'(CLK_HZ / 660);
         4'd4:    base = 32'(CLK_HZ / 698);
         4'd5:    base = 32'(CLK_HZ / 784);
         4'd6:    base = 32'(CLK_HZ / 880);
         4'd7:    base = 32'(CLK_HZ / 988);
         default: base = 32'd1;
      endcase
      if (oct == 2'b01)      half_of = base << 1;
      else if (oct == 2'b10) half_of = base >> 1;
      else                   half_of = base;
   endfunction

   // Entry = {octave, degree}; every song pattern repeats each 8 entries, slot 7 being a rest.
   function automatic logic [5:0] rom(input logic [6:0] song, input logic [2:0] p);
      logic [3:0] deg;
      logic [1:0] oct;
      oct = 2'b00;
      case (song)
         7'd0:    deg = {1'b0, p} + 4'd1;
         7'd1:    begin deg = 4'd7 - {1'b0, p}; oct = 2'b10; end
         7'd2:    begin deg = (({1'b0, p} * 4'd2) % 4'd7) + 4'd1; oct = 2'b01; end
         default: deg = p[0] ? 4'd5 : 4'd1;
      endcase
      if (p == 3'd7) deg = 4'd0;
      rom = {oct, deg};
   endfunction

   logic [2:0]  mode_q, mode_prev_q;
   logic [6:0]  key_q, key_prev_q;
   logic [1:0]  oct_q;
   logic        next_q, next_prev_q, prev_q, prev_prev_q;
   logic [6:0]  song_q, song_d;
   logic [7:0]  idx_q, idx_d;
   logic [31:0] tick_q, tick_d;
   logic [3:0]  note_q, note_d;
   logic [3:0]  tone_note_q, tone_note_d;
   logic [1:0]  tone_oct_q, tone_oct_d;
   logic [31:0] cnt_q, cnt_d;
   logic        spk_q, spk_d;

   logic        next_edge, prev_edge, clear;
   logic [7:0]  idx_cur, idx_next;
   logic [31:0] tick_cur, half;
   logic [5:0]  entry;
   logic [3:0]  key_deg;
   logic        key_single, key_press;

   always_comb begin
      next_edge = next_q & ~next_prev_q;
      prev_edge = prev_q & ~prev_prev_q;

      song_d = song_q;
      if (next_edge && !prev_edge)
         song_d = (song_q == SONG_LAST) ? 7'd0 : song_q + 7'd1;
      else if (prev_edge && !next_edge)
         song_d = (song_q == 7'd0) ? SONG_LAST : song_q - 7'd1;

      // A song or mode change restarts playback in the same cycle it is seen.
      clear    = (next_edge ^ prev_edge) || (mode_q != mode_prev_q);
      idx_cur  = clear ? 8'd0 : idx_q;
      tick_cur = clear ? 32'd0 : tick_q;
      idx_next = (idx_cur == IDX_LAST) ? 8'd0 : idx_cur + 8'd1;
      entry    = rom(song_d, idx_cur[2:0]);

      key_deg = 4'd0;
      for (int i = 6; i >= 0; i--)
         if (key_q[i]) key_deg = 4'(i + 1);
      key_single = (key_q != 7'd0) && ((key_q & (key_q - 7'd1)) == 7'd0);
      key_press  = key_single && ((key_q & key_prev_q) == 7'd0);

      idx_d       = idx_cur;
      tick_d      = tick_cur;
      note_d      = 4'd0;
      tone_note_d = 4'd0;
      tone_oct_d  = 2'b00;
      case (mode_q)
         MODE_FREE: begin
            note_d      = key_deg;
            tone_note_d = key_deg;
            tone_oct_d  = oct_q;
         end
         MODE_AUTO: begin
            note_d      = entry[3:0];
            tone_note_d = entry[3:0];
            tone_oct_d  = entry[5:4];
            if (tick_cur == TICK_LAST) begin
               tick_d = 32'd0;
               idx_d  = idx_next;
            end else begin
               tick_d = tick_cur + 32'd1;
            end
         end
         MODE_LEARN: begin
            note_d      = entry[3:0];
            tone_note_d = key_deg;
            tone_oct_d  = oct_q;
            if (entry[3:0] == 4'd0 || (key_press && key_deg == entry[3:0]))
               idx_d = idx_next;
         end
         default: ;
      endcase

      half = half_of(tone_note_q, tone_oct_q);
      if (tone_note_d != tone_note_q || tone_oct_d != tone_oct_q) begin
         cnt_d = 32'd0;
         spk_d = 1'b0;
      end else if (tone_note_q == 4'd0) begin
         cnt_d = 32'd0;
         spk_d = 1'b0;
      end else if (cnt_q == half - 32'd1) begin
         cnt_d = 32'd0;
         spk_d = ~spk_q;
      end else begin
         cnt_d = cnt_q + 32'd1;
         spk_d = spk_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q      <= '0;
         mode_prev_q <= '0;
         key_q       <= '0;
         key_prev_q  <= '0;
         oct_q       <= '0;
         next_q      <= 1'b0;
         next_prev_q <= 1'b0;
         prev_q      <= 1'b0;
         prev_prev_q <= 1'b0;
         song_q      <= '0;
         idx_q       <= '0;
         tick_q      <= '0;
         note_q      <= '0;
         tone_note_q <= '0;
         tone_oct_q  <= '0;
         cnt_q       <= '0;
         spk_q       <= 1'b0;
      end else begin
         mode_q      <= bus.mode_select;
         mode_prev_q <= mode_q;
         key_q       <= bus.key_in;
         key_prev_q  <= key_q;
         oct_q       <= bus.octave_keys;
         next_q      <= bus.next_song;
         next_prev_q <= next_q;
         prev_q      <= bus.prev_song;
         prev_prev_q <= prev_q;
         song_q      <= song_d;
         idx_q       <= idx_d;
         tick_q      <= tick_d;
         note_q      <= note_d;
         tone_note_q <= tone_note_d;
         tone_oct_q  <= tone_oct_d;
         cnt_q       <= cnt_d;
         spk_q       <= spk_d;
      end
   end

   assign bus.speaker  = spk_q;
   assign bus.song_num = song_q;
   assign bus.note_out = note_q;

endmodule

// File: tb/tb_main.sv
// tb/tb_main.sv - self-checking bench for the keyboard controller
// Small CLK_HZ and NOTE_TICKS keep tone periods and note lengths short.
module tb_main;
   localparam int CLK_HZ     = 20000;
   localparam int NOTE_TICKS = 10;
   localparam int NUM_SONGS  = 4;
   localparam int SONG_LEN   = 16;
   localparam int FREQ [7]   = '{262, 294, 330, 349, 392, 440, 494};

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   main_if bus ();

   main #(
      .CLK_HZ(CLK_HZ), .NOTE_TICKS(NOTE_TICKS), .NUM_SONGS(NUM_SONGS), .SONG_LEN(SONG_LEN)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic int half_ref(int deg, logic [1:0] oct);
      int h;
      h = CLK_HZ / (2 * FREQ[deg - 1]);
      if (oct == 2'b01) return h * 2;
      if (oct == 2'b10) return h / 2;
      return h;
   endfunction

   function automatic int song0_deg(int i);
      return (i % 8 == 7) ? 0 : (i % 8) + 1;
   endfunction

   function automatic int prio_deg(logic [6:0] k);
      int v;
      v = int'(k);
      if (v == 0) return 0;
      return $clog2(v & -v) + 1;
   endfunction

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.mode_select = 3'd0;
      bus.key_in      = 7'd0;
      bus.octave_keys = 2'b00;
      bus.next_song   = 1'b0;
      bus.prev_song   = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      cyc(5);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.mode_select = 3'($urandom);
         bus.key_in      = 7'($urandom);
         bus.octave_keys = 2'($urandom);
         bus.next_song   = 1'($urandom);
         bus.prev_song   = 1'($urandom);
         cyc(1);
      end
      checks++;
      if (bus.speaker !== 1'b0 || bus.song_num !== 7'd0 || bus.note_out !== 4'd0) begin
         errors++;
         $display("FAIL reset_hold: spk=%b song=%0d note=%0d, want 0/0/0", bus.speaker, bus.song_num, bus.note_out);
      end
      idle_inputs();
      reset = 1'b0;
      cyc(3);
      checks++;
      if (bus.speaker !== 1'b0 || bus.song_num !== 7'd0 || bus.note_out !== 4'd0) begin
         errors++;
         $display("FAIL reset_release: spk=%b song=%0d note=%0d, want 0/0/0", bus.speaker, bus.song_num, bus.note_out);
      end
   endtask

   task automatic test_free_tone(input int deg, input logic [1:0] oct);
      int   h, n;
      logic prev;
      bus.mode_select = 3'd0;
      bus.key_in = 7'd0;
      cyc(3);
      bus.key_in      = 7'(1 << (deg - 1));
      bus.octave_keys = oct;
      cyc(1);
      checks++;
      if (bus.note_out !== 4'd0) begin
         errors++;
         $display("FAIL free_latency1 d%0d: note=%0d, want 0", deg, bus.note_out);
      end
      cyc(1);
      checks++;
      if (bus.note_out !== 4'(deg) || bus.speaker !== 1'b0) begin
         errors++;
         $display("FAIL free_note d%0d: note=%0d spk=%b, want %0d/0", deg, bus.note_out, bus.speaker, deg);
      end
      h = half_ref(deg, oct);
      for (int t = 0; t < 2; t++) begin
         n = 0;
         prev = bus.speaker;
         do begin
            cyc(1);
            n++;
         end while (bus.speaker === prev && n <= 4 * h);
         checks++;
         if (n != h) begin
            errors++;
            $display("FAIL free_period d%0d oct%b toggle%0d: %0d cycles, want %0d", deg, oct, t, n, h);
         end
      end
   endtask

   task automatic test_priority();
      logic [6:0] k;
      int         hi;
      bus.mode_select = 3'd0;
      bus.octave_keys = 2'b00;
      bus.key_in = 7'b0000110;
      cyc(2);
      checks++;
      if (bus.note_out !== 4'd2) begin
         errors++;
         $display("FAIL prio_0000110: note=%0d, want 2", bus.note_out);
      end
      for (int i = 0; i < 8; i++) begin
         k = 7'($urandom_range(1, 127));
         bus.key_in = k;
         cyc(2);
         checks++;
         if (bus.note_out !== 4'(prio_deg(k))) begin
            errors++;
            $display("FAIL prio_rand key=%b: note=%0d, want %0d", k, bus.note_out, prio_deg(k));
         end
      end
      bus.key_in = 7'd0;
      cyc(2);
      checks++;
      if (bus.note_out !== 4'd0) begin
         errors++;
         $display("FAIL free_nokey: note=%0d, want 0", bus.note_out);
      end
      hi = 0;
      for (int i = 0; i < 60; i++) begin
         cyc(1);
         if (bus.speaker !== 1'b0) hi++;
      end
      checks++;
      if (hi != 0) begin
         errors++;
         $display("FAIL free_silent: speaker high %0d cycles, want 0", hi);
      end
   endtask

   task automatic test_auto();
      int bad, hi, want;
      bus.key_in = 7'd0;
      bus.mode_select = 3'd3;
      cyc(3);
      bus.mode_select = 3'd1;
      cyc(1);
      checks++;
      if (bus.note_out !== 4'd0) begin
         errors++;
         $display("FAIL auto_latency1: note=%0d, want 0", bus.note_out);
      end
      cyc(1);
      bad = 0;
      for (int c = 0; c < 2 * SONG_LEN * NOTE_TICKS; c++) begin
         want = song0_deg((c / NOTE_TICKS) % SONG_LEN);
         checks++;
         if (bus.note_out !== 4'(want) || bus.speaker !== 1'b0) begin
            errors++;
            bad++;
            if (bad <= 5)
               $display("FAIL auto_seq cycle%0d: note=%0d spk=%b, want %0d/0", c, bus.note_out, bus.speaker, want);
         end
         cyc(1);
      end
      bus.mode_select = 3'd3;
      cyc(2);
      checks++;
      if (bus.note_out !== 4'd0) begin
         errors++;
         $display("FAIL auto_to_idle: note=%0d, want 0", bus.note_out);
      end
      hi = 0;
      for (int i = 0; i < 30; i++) begin
         cyc(1);
         if (bus.speaker !== 1'b0 || bus.note_out !== 4'd0) hi++;
      end
      checks++;
      if (hi != 0) begin
         errors++;
         $display("FAIL idle_quiet: %0d active cycles, want 0", hi);
      end
   endtask

   task automatic test_song_select();
      int         ms;
      logic [1:0] ops [$];
      logic [1:0] op;
      ms = int'(bus.song_num);
      bus.mode_select = 3'd3;
      ops = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11};
      for (int i = 0; i < 10; i++) ops.push_back(2'($urandom_range(1, 3)));
      foreach (ops[i]) begin
         op = ops[i];
         bus.next_song = op[0];
         bus.prev_song = op[1];
         cyc(1);
         checks++;
         if (bus.song_num !== 7'(ms)) begin
            errors++;
            $display("FAIL song_early op%0d: song=%0d, want %0d", i, bus.song_num, ms);
         end
         cyc(1);
         if (op == 2'b01) ms = (ms + 1) % NUM_SONGS;
         else if (op == 2'b10) ms = (ms + NUM_SONGS - 1) % NUM_SONGS;
         checks++;
         if (bus.song_num !== 7'(ms)) begin
            errors++;
            $display("FAIL song_step op%0d(%b): song=%0d, want %0d", i, op, bus.song_num, ms);
         end
         cyc(2);
         bus.next_song = 1'b0;
         bus.prev_song = 1'b0;
         cyc(2);
         checks++;
         if (bus.song_num !== 7'(ms)) begin
            errors++;
            $display("FAIL song_held op%0d: song=%0d, want %0d", i, bus.song_num, ms);
         end
      end
   endtask

   task automatic test_learn();
      int         idx, r, exp_deg;
      logic [6:0] k;
      do_reset();
      bus.mode_select = 3'd2;
      cyc(2);
      checks++;
      if (bus.note_out !== 4'd1) begin
         errors++;
         $display("FAIL learn_start: note=%0d, want 1", bus.note_out);
      end
      bus.key_in = 7'b0000010;
      cyc(2);
      bus.key_in = 7'd0;
      cyc(4);
      checks++;
      if (bus.note_out !== 4'd1) begin
         errors++;
         $display("FAIL learn_wrong: note=%0d, want 1", bus.note_out);
      end
      bus.key_in = 7'b0000001;
      cyc(2);
      bus.key_in = 7'd0;
      cyc(4);
      checks++;
      if (bus.note_out !== 4'd2 || bus.speaker !== 1'b0) begin
         errors++;
         $display("FAIL learn_right: note=%0d spk=%b, want 2/0", bus.note_out, bus.speaker);
      end
      reset = 1'b1;
      cyc(3);
      reset = 1'b0;
      cyc(2);
      checks++;
      if (bus.note_out !== 4'd1) begin
         errors++;
         $display("FAIL learn_reset: note=%0d, want 1", bus.note_out);
      end
      idx = 0;
      for (int i = 0; i < 40; i++) begin
         exp_deg = song0_deg(idx);
         r = $urandom_range(0, 3);
         case (r)
            0:       k = 7'(1 << (exp_deg - 1));
            1:       k = 7'(1 << $urandom_range(0, 6));
            2:       k = 7'($urandom_range(1, 127));
            default: k = 7'(1 << (exp_deg - 1)) | 7'(1 << ((exp_deg % 7)));
         endcase
         bus.key_in = k;
         cyc(2);
         bus.key_in = 7'd0;
         cyc(4);
         if ($countones(k) == 1 && prio_deg(k) == exp_deg) idx = (idx + 1) % SONG_LEN;
         while (song0_deg(idx) == 0) idx = (idx + 1) % SONG_LEN;
         checks++;
         if (bus.note_out !== 4'(song0_deg(idx)) || bus.speaker !== 1'b0) begin
            errors++;
            $display("FAIL learn_walk step%0d key=%b: note=%0d spk=%b, want %0d/0",
                     i, k, bus.note_out, bus.speaker, song0_deg(idx));
         end
      end
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      test_reset();
      test_free_tone(1, 2'b00);
      test_free_tone(1, 2'b01);
      test_free_tone(7, 2'b10);
      test_free_tone($urandom_range(1, 7), 2'b11);
      test_free_tone($urandom_range(1, 7), 2'($urandom));
      test_priority();
      test_auto();
      test_song_select();
      test_learn();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/main.md
# main

Top-level controller of the electronic keyboard. It turns seven note keys, two octave keys, song-select buttons and a mode selector into a square-wave tone on `speaker`. It also drives the current song index and note code to the display logic. It supports three modes: free play, auto play from an internal song ROM, and learning (guided play).

## Interface
Parameters:
- CLK_HZ, 50_000_000, system clock frequency; used to derive tone half-periods
- NOTE_TICKS, 12_500_000, clock cycles each auto-play note lasts (0.25 s)
- NUM_SONGS, 4, number of songs in ROM
- SONG_LEN, 16, entries per song

Ports:
- clk  in  1  system clock; the block has one clock
- reset  in  1  reset is synchronous and active-high
- mode_select  in  3  0 = free, 1 = auto, 2 = learn, 3–7 = idle
- key_in  in  7  note keys; bit0 = degree 1 (do) … bit6 = degree 7 (si)
- octave_keys  in  2  bit0 = low octave, bit1 = high octave; 00 or 11 = middle
- next_song  in  1  level button; its rising edge selects the next song
- prev_song  in  1  level button; its rising edge selects the previous song
- speaker  out  1  square-wave tone output
- song_num  out  7  current song index, zero-extended
- note_out  out  4  current note degree: 0 = rest, 1–7 = degree; 8–15 never driven

## Operation
- All inputs are registered once (`*_q`). Button edges are detected as `q & ~q_prev`.
- Key priority: when several keys are pressed, the lowest set bit of `key_in` wins.
- Free mode (0):
  - note = priority key degree, or 0 if no key is pressed.
  - octave comes from `octave_keys`.
- Auto mode (1):
  - Plays ROM[song][idx] for NOTE_TICKS cycles, then increments idx.
  - idx wraps from SONG_LEN-1 to 0, so the song loops.
  - Each ROM entry is {octave 2b, degree 4b}.
  - Song 0 is fixed: 1,2,3,4,5,6,7,0 twice, all middle octave. Songs 1..NUM_SONGS-1 are implementer-defined and non-empty.
- Learn mode (2):
  - note_out = degree of ROM[song][idx], which is the expected note.
  - speaker sounds the pressed key, as in free mode; it is silent when no key is pressed.
  - On a rising edge of a single-key press whose degree matches the expected degree, idx advances (with wrap).
  - Wrong keys do not advance idx.
  - Rest entries (degree 0) are skipped automatically after 1 cycle.
- Idle modes (3–7): speaker = 0, note_out = 0, idx is held.
- Song select:
  - A next_song edge increments song with wrap (NUM_SONGS-1 → 0).
  - A prev_song edge decrements song with wrap (0 → NUM_SONGS-1).
  - Edges on both buttons in the same cycle are ignored.
  - Any song change clears idx and the tick timer.
- A change of mode_select clears idx and the tick timer.
- Tone generation:
  - Middle-octave frequencies: 262, 294, 330, 349, 392, 440, 494 Hz.
  - half = CLK_HZ/(2·f), integer-truncated.
  - Low octave uses half·2; high octave uses half/2.
  - A counter runs 0..half-1; speaker toggles when the counter reaches half-1.
  - When note or octave changes, the counter clears and speaker is forced to 0 for that cycle.
  - When note = 0, speaker = 0 and the counter is held at 0.

## Timing
- Reset values: speaker 0, song_num 0, note_out 0, idx 0, tick timer 0, counter 0, all edge registers 0.
- Reset takes priority over all other activity, including mid-song.
- Latency: a change on key_in, octave_keys or mode_select reaches note_out 2 clocks later (input register, then output register).
- First speaker toggle occurs half cycles after note_out changes.
- Button edge → song_num updates 2 clocks after the input edge.
- Auto mode: the first note appears on note_out 2 clocks after entering mode 1. Each note is held for exactly NOTE_TICKS cycles.
- No handshakes. Buttons held high generate only one edge.

## Test plan
- Reset held 5 cycles, then released → speaker=0, song_num=0, note_out=0.
- Free mode, key_in=0000001, octave_keys=00 → note_out=1 after 2 clk; speaker toggles every 95419 cycles. Same key with octave_keys=01 → toggles every 190838 cycles.
- Free mode, key_in=0000110 → note_out=2 (priority); key_in=0 → note_out=0 and speaker stays 0.
- Auto mode, song 0, NUM_SONGS=4, NOTE_TICKS=10 (override) → note_out sequence 1..7,0 repeating, each value held for 10 cycles; mode_select=3 → note_out=0, speaker=0.
- next_song pulse ×4 → song_num goes 1, 2, 3, 0. prev_song from 0 → 3. Both pulsed in the same cycle → unchanged.
- Learn mode, song 0 → note_out=1:
  - key_in=0000010 (wrong key) → note_out stays 1.
  - Press and release key_in=0000001 → note_out=2.
  - Reset mid-song → note_out returns to 1 in learn mode.
